// File: rtl/ray_angle_sequencer.sv
// ray_angle_sequencer: steps one ray angle per screen column across the field of view each frame
// Optional output ray_quadrant is enabled by defining RAY_ANGLE_QUADRANT_EN.
// Ports: clock, reset (async, active high); start frame request; player_angle heading in degrees;
//        ray_ready downstream accept; ray_valid/ray_angle_X/ray_angle_Y/slice_idx current ray;
//        busy frame in progress; frame_done one-cycle end-of-frame pulse; ray_quadrant = X/90 (optional).
module ray_angle_sequencer #(
  parameter int NUM_SLICES = 160,
  parameter int STEP_Y     = 375,
  parameter int FOV_HALF   = 30
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] player_angle,
  input  logic       ray_ready,
  output logic       ray_valid,
  output logic [8:0] ray_angle_X,
  output logic [9:0] ray_angle_Y,
  output logic [7:0] slice_idx,
  output logic       busy,
`ifdef RAY_ANGLE_QUADRANT_EN
  output logic [1:0] ray_quadrant,
`endif
  output logic       frame_done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t      state_q;
  logic [8:0]  a_d, x0_d, x_inc, x_d;
  logic [10:0] y_sum;
  logic [9:0]  y_d;
  logic        carry;
  always_comb begin
    a_d   = player_angle >= 9'd360 ? player_angle - 9'd360 : player_angle;
    x0_d  = a_d < 9'(FOV_HALF) ? a_d + 9'(360 - FOV_HALF) : a_d - 9'(FOV_HALF);
    y_sum = {1'b0, ray_angle_Y} + 11'(STEP_Y);
    carry = y_sum >= 11'd1000;
    y_d   = carry ? 10'(y_sum - 11'd1000) : y_sum[9:0];
    x_inc = ray_angle_X == 9'd359 ? 9'd0 : ray_angle_X + 9'd1;
    x_d   = carry ? x_inc : ray_angle_X;
  end
`ifdef RAY_ANGLE_QUADRANT_EN
  function automatic logic [1:0] quad(input logic [8:0] x);
    return x >= 9'd270 ? 2'd3 : x >= 9'd180 ? 2'd2 : x >= 9'd90 ? 2'd1 : 2'd0;
  endfunction
`endif
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ray_valid   <= 1'b0;
      ray_angle_X <= '0;
      ray_angle_Y <= '0;
      slice_idx   <= '0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
`ifdef RAY_ANGLE_QUADRANT_EN
      ray_quadrant <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q     <= RUN;
          ray_valid   <= 1'b1;
          busy        <= 1'b1;
          ray_angle_X <= x0_d;
          ray_angle_Y <= '0;
          slice_idx   <= '0;
`ifdef RAY_ANGLE_QUADRANT_EN
          ray_quadrant <= quad(x0_d);
`endif
        end
        RUN: if (ray_ready) begin
          if (slice_idx == 8'(NUM_SLICES - 1)) begin
            state_q    <= DONE;
            ray_valid  <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            slice_idx   <= slice_idx + 8'd1;
            ray_angle_X <= x_d;
            ray_angle_Y <= y_d;
`ifdef RAY_ANGLE_QUADRANT_EN
            ray_quadrant <= quad(x_d);
`endif
          end
        end
        DONE: begin
          state_q    <= IDLE;
          frame_done <= 1'b0;
          busy       <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ray_angle_sequencer.sv
// tb_ray_angle_sequencer: scoreboard bench for ray_angle_sequencer
module tb_ray_angle_sequencer;
  logic       clock = 0, reset = 1, start = 0, ray_ready = 0;
  logic [8:0] player_angle = 0;
  logic       ray_valid, busy, frame_done;
  logic [8:0] ray_angle_X;
  logic [9:0] ray_angle_Y;
  logic [7:0] slice_idx;
`ifdef RAY_ANGLE_QUADRANT_EN
  logic [1:0] ray_quadrant;
`endif
  ray_angle_sequencer dut (
    .clock(clock), .reset(reset), .start(start), .player_angle(player_angle),
    .ray_ready(ray_ready), .ray_valid(ray_valid), .ray_angle_X(ray_angle_X),
    .ray_angle_Y(ray_angle_Y), .slice_idx(slice_idx), .busy(busy),
`ifdef RAY_ANGLE_QUADRANT_EN
    .ray_quadrant(ray_quadrant),
`endif
    .frame_done(frame_done)
  );
  always #5 clock = ~clock;
  int errors = 0, checks = 0, cyc = 0, last_acc = -10, fd_cnt = 0, cur_ang = 0;
  int qx[$], qy[$], qs[$];
  bit prev_fd = 0;
  int sp [8][4] = '{'{10, 0, 340, 0}, '{10, 1, 340, 375}, '{10, 3, 341, 125}, '{10, 159, 39, 625},
                   '{0, 0, 330, 0}, '{0, 80, 0, 0}, '{0, 159, 29, 625}, '{400, 0, 10, 0}};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (!reset) begin
    int x, y, s;
    if (prev_fd) chk("fd_pulse", frame_done, 0);
    if (frame_done) begin
      fd_cnt++;
      chk("fd_lat", cyc - last_acc, 1);
      chk("fd_qempty", qs.size(), 0);
      chk("fd_busy", busy, 1);
      chk("fd_valid", ray_valid, 0);
    end
    prev_fd = frame_done;
    if (ray_valid && ray_ready) begin
      chk("sb_nonempty", qs.size() > 0, 1);
      if (qs.size() > 0) begin
        x = qx.pop_front(); y = qy.pop_front(); s = qs.pop_front();
        chk("sb_slice", slice_idx, s);
        chk("sb_x", ray_angle_X, x);
        chk("sb_y", ray_angle_Y, y);
`ifdef RAY_ANGLE_QUADRANT_EN
        chk("sb_quad", ray_quadrant, x / 90);
`endif
      end
      for (int k = 0; k < 8; k++)
        if (cur_ang == sp[k][0] && slice_idx == sp[k][1]) begin
          chk("spot_x", ray_angle_X, sp[k][2]);
          chk("spot_y", ray_angle_Y, sp[k][3]);
        end
      last_acc = cyc;
    end
  end
  // mode: 0 ready=1, 1 random ready, 2 stall at slice 2, 3 start/angle noise, 4 reset at slice 50
  task automatic frame(input int ang, input int mode);
    int a, x0, t, f0, n;
    bit stalled;
    logic [8:0] hx; logic [9:0] hy; logic [7:0] hs;
    a = ang >= 360 ? ang - 360 : ang;
    x0 = (a + 330) % 360;
    for (int i = 0; i < 160; i++) begin
      t = x0 * 1000 + i * 375;
      qx.push_back((t / 1000) % 360);
      qy.push_back(t % 1000);
      qs.push_back(i);
    end
    cur_ang = ang;
    f0 = fd_cnt;
    stalled = 0;
    @(posedge clock); #1 start = 1; player_angle = 9'(ang); ray_ready = mode == 1 ? 1'($urandom % 2) : 1'b1;
    @(posedge clock); #1 start = 0;
    chk("latency_valid", ray_valid, 1);
    chk("run_busy", busy, 1);
    n = 0;
    while (fd_cnt == f0 && n < 3000) begin
      n++;
      if (mode == 2 && slice_idx == 2 && !stalled) begin
        stalled = 1; ray_ready = 0; hx = ray_angle_X; hy = ray_angle_Y; hs = slice_idx;
        repeat (5) begin
          @(posedge clock); #1;
          chk("hold_valid", ray_valid, 1);
          chk("hold_x", ray_angle_X, hx);
          chk("hold_y", ray_angle_Y, hy);
          chk("hold_slice", slice_idx, hs);
        end
        ray_ready = 1;
      end else if (mode == 4 && slice_idx == 50) begin
        #2 reset = 1;
        #1;
        chk("arst_valid", ray_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_fd", frame_done, 0);
        chk("arst_x", ray_angle_X, 0);
        chk("arst_y", ray_angle_Y, 0);
        chk("arst_slice", slice_idx, 0);
        qx.delete(); qy.delete(); qs.delete();
        @(posedge clock); #1 reset = 0; ray_ready = 0;
        repeat (20) @(posedge clock);
        #1 chk("abort_no_fd", fd_cnt, f0);
        chk("abort_idle", busy, 0);
        return;
      end else begin
        if (mode == 1) ray_ready = 1'($urandom % 2);
        if (mode == 3) begin start = 1'($urandom % 2); player_angle = 9'($urandom % 512); end
        @(posedge clock); #1;
      end
    end
    start = 0; ray_ready = 0;
    chk("frame_end", fd_cnt, f0 + 1);
    chk("idle_busy", busy, 0);
    chk("idle_valid", ray_valid, 0);
  endtask
  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", ray_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frame_done, 0);
    chk("rst_x", ray_angle_X, 0);
    chk("rst_y", ray_angle_Y, 0);
    chk("rst_slice", slice_idx, 0);
    reset = 0;
    frame(10, 0);
    frame(0, 0);
    frame(10, 2);
    frame(200, 1);
    frame(100, 3);
    frame(77, 4);
    frame(400, 0);
    frame(359, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ray_angle_sequencer.md
RAY_ANGLE_SEQUENCER -- requirements
Module: ray_angle_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_SLICES, default 160, meaning screen columns (rays) per frame.
REQ-002 The block SHALL have parameter STEP_Y, default 375, meaning per-slice angle increment in thousandths of a degree.
REQ-003 The block SHALL have parameter FOV_HALF, default 30, meaning half field of view in whole degrees.
REQ-004 The block SHALL have port clock, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit, meaning a frame-request pulse.
REQ-007 The block SHALL have port player_angle, input, 9 bits, meaning the player heading in whole degrees.
REQ-008 The block SHALL have port ray_ready, input, 1 bit, meaning the downstream raycaster accepts the current ray.
REQ-009 The block SHALL have port ray_valid, output, 1 bit, meaning ray_angle_X, ray_angle_Y and slice_idx hold a valid ray.
REQ-010 The block SHALL have port ray_angle_X, output, 9 bits, meaning the integer degrees of the ray angle, 0..359.
REQ-011 The block SHALL have port ray_angle_Y, output, 10 bits, meaning the fractional thousandths of the ray angle, 0..999.
REQ-012 The block SHALL have port slice_idx, output, 8 bits, meaning the column index, 0..NUM_SLICES-1.
REQ-013 The block SHALL have port busy, output, 1 bit, meaning a frame is in progress.
REQ-014 The block SHALL have port frame_done, output, 1 bit, meaning a one-cycle pulse after the last ray is accepted.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE.
REQ-016 In IDLE with start=1, it SHALL latch A = player_angle (minus 360 if >=359... i.e. if >=360), set X = A-FOV_HALF (+360 if negative), Y=0, slice_idx=0, and enter RUN.
REQ-017 In RUN, ray_valid SHALL be 1, and the first ray SHALL be valid on the cycle after start is sampled (1-cycle latency).
REQ-018 While ray_valid=1 and ray_ready=0, all ray outputs SHALL hold stable.
REQ-019 On ray_valid&&ray_ready with slice_idx<NUM_SLICES-1: slice_idx+1; Y+=STEP_Y; if sum>=1000 then Y-=1000 and X+1; X SHALL wrap 360->0.
REQ-020 On ray_valid&&ray_ready with slice_idx=NUM_SLICES-1, the block SHALL enter DONE and drive ray_valid=0.
REQ-021 DONE SHALL assert frame_done for exactly one cycle and then return to IDLE; busy SHALL be 1 in RUN and DONE.
REQ-022 start SHALL be ignored outside IDLE, and player_angle changes after the latch SHALL have no effect.
REQ-023 Internal Y sum width SHALL be at least 11 bits (max 999+STEP_Y), and STEP_Y SHALL be <1000.

Reset
REQ-024 reset=1 SHALL force state IDLE, ray_valid=0, busy=0, frame_done=0, ray_angle_X=0, ray_angle_Y=0, slice_idx=0, regardless of clock.
REQ-025 Reset mid-frame SHALL abort the frame without a frame_done pulse, and the next start SHALL begin at slice 0.

Configuration
REQ-026 With macro RAY_ANGLE_QUADRANT_EN defined, the block SHALL add output ray_quadrant, 2 bits, registered alongside the ray outputs, equal to ray_angle_X/90 (0..3) and reset to 0.
REQ-027 With RAY_ANGLE_QUADRANT_EN undefined, the block SHALL omit the ray_quadrant port and its logic, with all other behaviour identical.

Verification
REQ-028 player_angle=10, start, ray_ready=1 -> slice 0: X=340 Y=0; slice 1: 340/375; slice 3: 341/125; slice 159: 39/625; frame_done one cycle after slice 159 is accepted.
REQ-029 player_angle=0 -> slice 0: 330/000; slice 80: 0/000 (wrap 360->0); slice 159: 29/625.
REQ-030 ray_ready held 0 for 5 cycles at slice 2 -> ray_valid=1 and X/Y/slice_idx are unchanged for all 5 cycles; slice 3 follows the cycle after ready rises.
REQ-031 start pulsed during RUN, and player_angle changed mid-frame -> no restart and the angle sequence is unaffected.
REQ-032 reset asserted at slice 50 -> all outputs 0 asynchronously with no frame_done; a new start gives slice 0 with a freshly computed angle.
REQ-033 player_angle=400 -> treated as 40, so slice 0: X=10 Y=0; with RAY_ANGLE_QUADRANT_EN, X=95 gives ray_quadrant=1 and X=359 gives 3.
